// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter and its winner-select helper.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam int DEFAULT_ACCESS_CYCLES = 2;
    localparam int CNT_W                 = 3;

endpackage

// File: rtl/sram_arbiter_pick.sv
// Combinational winner selection: A by default, B when alone or when A won the previous grant.
module sram_arbiter_pick
    import sram_arbiter_pkg::*;
(
    input  logic  a_req,
    input  logic  b_req,
    input  port_t prev_grant,
    output logic  any_req,
    output port_t winner
);

    always_comb begin
        any_req = a_req | b_req;
        if (b_req && (!a_req || prev_grant == PORT_A)) begin
            winner = PORT_B;
        end else begin
            winner = PORT_A;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the external 16-bit asynchronous SRAM.
// Optional byte-lane strobes (a_be/b_be, UB/LB) are built when SRAM_ARBITER_BYTE_LANES_EN is defined.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [17:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [17:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic [17:0] address_pins,
    output logic [15:0] data_pins_out,
    output logic        data_pins_out_en,
    input  logic [15:0] data_pins_in,
    output logic        CS,
    output logic        OE,
    output logic        WE,
`ifdef SRAM_ARBITER_BYTE_LANES_EN
    input  logic [1:0]  a_be,
    input  logic [1:0]  b_be,
    output logic        UB,
    output logic        LB,
`endif
    output logic        busy,
    output logic        grant_b
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    port_t              prev_q, prev_d;
    logic               grant_b_q, grant_b_d;
    logic               write_q, write_d;
    logic [17:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               dout_en_q, dout_en_d;
    logic               cs_n_q, cs_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               a_ack_q, a_ack_d;
    logic               b_ack_q, b_ack_d;
    logic [15:0]        a_rdata_q, a_rdata_d;
    logic [15:0]        b_rdata_q, b_rdata_d;
    logic               busy_q, busy_d;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
    logic               ub_n_q, ub_n_d;
    logic               lb_n_q, lb_n_d;
    logic [1:0]         sel_be;
`endif

    logic  any_req;
    port_t winner;
    logic  sel_write;

    sram_arbiter_pick u_pick (
        .a_req      (a_req),
        .b_req      (b_req),
        .prev_grant (prev_q),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_comb begin
        // NOTE: every _d starts from its _q (or idle value), so no branch below can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        grant_b_d = grant_b_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dout_en_d = dout_en_q;
        cs_n_d    = cs_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        busy_d    = busy_q;
        sel_write = (winner == PORT_B) ? b_we : a_we;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
        ub_n_d    = ub_n_q;
        lb_n_d    = lb_n_q;
        sel_be    = (winner == PORT_B) ? b_be : a_be;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = ACCESS;
                    cnt_d     = CNT_W'(ACCESS_CYCLES);
                    prev_d    = winner;
                    grant_b_d = (winner == PORT_B);
                    write_d   = sel_write;
                    addr_d    = (winner == PORT_B) ? b_addr  : a_addr;
                    wdata_d   = (winner == PORT_B) ? b_wdata : a_wdata;
                    cs_n_d    = 1'b0;
                    oe_n_d    = sel_write;
                    we_n_d    = !sel_write;
                    dout_en_d = sel_write;
                    busy_d    = 1'b1;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
                    // Reads always enable both lanes; writes enable only the requested bytes.
                    ub_n_d    = sel_write ? !sel_be[1] : 1'b0;
                    lb_n_d    = sel_write ? !sel_be[0] : 1'b0;
`endif
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RECOVER;
                    cs_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
`endif
                    if (!write_q) begin
                        if (grant_b_q) b_rdata_d = data_pins_in;
                        else           a_rdata_d = data_pins_in;
                    end
                    a_ack_d = !grant_b_q;
                    b_ack_d = grant_b_q;
                end
            end
            RECOVER: begin
                // Address and write data keep driving through this cycle for SRAM hold time.
                state_d   = IDLE;
                dout_en_d = 1'b0;
                busy_d    = 1'b0;
                grant_b_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= PORT_B;
            grant_b_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dout_en_q <= 1'b0;
            cs_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            busy_q    <= 1'b0;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            grant_b_q <= grant_b_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dout_en_q <= dout_en_d;
            cs_n_q    <= cs_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
`endif
        end
    end

    assign a_ack            = a_ack_q;
    assign b_ack            = b_ack_q;
    assign a_rdata          = a_rdata_q;
    assign b_rdata          = b_rdata_q;
    assign address_pins     = addr_q;
    assign data_pins_out    = wdata_q;
    assign data_pins_out_en = dout_en_q;
    assign CS               = cs_n_q;
    assign OE               = oe_n_q;
    assign WE               = we_n_q;
    assign busy             = busy_q;
    assign grant_b          = grant_b_q;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
    assign UB               = ub_n_q;
    assign LB               = lb_n_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_sram_arbiter;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req, a_we, b_we;
    logic [17:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic [17:0] address_pins;
    logic [15:0] data_pins_out;
    logic        data_pins_out_en;
    logic [15:0] data_pins_in;
    logic        CS, OE, WE, busy, grant_b;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
    logic [1:0]  a_be, b_be;
    logic        UB, LB;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: last grant (1 = B) and each port's most recently read word.
    bit          model_prev_b = 1'b1;
    logic [15:0] exp_a_rdata  = 16'h0;
    logic [15:0] exp_b_rdata  = 16'h0;

    sram_arbiter #(.ACCESS_CYCLES(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_addr           (a_addr),
        .a_wdata          (a_wdata),
        .a_ack            (a_ack),
        .a_rdata          (a_rdata),
        .b_req            (b_req),
        .b_we             (b_we),
        .b_addr           (b_addr),
        .b_wdata          (b_wdata),
        .b_ack            (b_ack),
        .b_rdata          (b_rdata),
        .address_pins     (address_pins),
        .data_pins_out    (data_pins_out),
        .data_pins_out_en (data_pins_out_en),
        .data_pins_in     (data_pins_in),
        .CS               (CS),
        .OE               (OE),
        .WE               (WE),
`ifdef SRAM_ARBITER_BYTE_LANES_EN
        .a_be             (a_be),
        .b_be             (b_be),
        .UB               (UB),
        .LB               (LB),
`endif
        .busy             (busy),
        .grant_b          (grant_b)
    );

    always #5 clk = ~clk;

    // Arbitration rule: contention alternates away from the last grant, otherwise the lone requester wins.
    function automatic bit model_pick(bit a, bit b, bit prev_b);
        if (a && b) return !prev_b;
        return b;
    endfunction

    task automatic idle_inputs();
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        data_pins_in = '0;
`ifdef SRAM_ARBITER_BYTE_LANES_EN
        a_be = 2'b11; b_be = 2'b11;
`endif
    endtask

    task automatic test_reset();
        int ack_seen;
        ack_seen = 0;
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({CS, OE, WE, data_pins_out_en, a_ack, b_ack, busy, grant_b} !== 8'b1110_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", {CS, OE, WE, data_pins_out_en, a_ack, b_ack, busy, grant_b}, 8'b1110_0000);
        end
        checks++;
        if ({address_pins, data_pins_out, a_rdata, b_rdata} !== 66'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {address_pins, data_pins_out, a_rdata, b_rdata});
        end
        reset = 1'b1;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00100; a_wdata = 16'h5A5A;
        @(negedge clk);
        checks++;
        if ({CS, WE, busy} !== 3'b001) begin
            errors++;
            $display("FAIL reset_write_started: got %b expected 001", {CS, WE, busy});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({CS, OE, WE, data_pins_out_en, busy, address_pins} !== {5'b11100, 18'h0}) begin
            errors++;
            $display("FAIL reset_midwrite: got %h expected %h", {CS, OE, WE, data_pins_out_en, busy, address_pins}, {5'b11100, 18'h0});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_ack !== 1'b0) ack_seen++;
        end
        a_req = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_ack !== 1'b0 || busy !== 1'b0) ack_seen++;
        end
        checks++;
        if (ack_seen != 0) begin
            errors++;
            $display("FAIL reset_no_ack: got %0d ack/busy cycles expected 0", ack_seen);
        end
        model_prev_b = 1'b1;
        exp_a_rdata  = 16'h0;
        exp_b_rdata  = 16'h0;
    endtask

    task automatic test_single_read();
        int strobe_cnt, ack_at;
        strobe_cnt = 0; ack_at = 0;
        data_pins_in = 16'hAA55;
        a_req = 1'b1; a_we = 1'b0; a_addr = 18'h3F000;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (a_ack === 1'b1) begin
                ack_at = k;
                break;
            end
            if (CS === 1'b0 && OE === 1'b0 && WE === 1'b1 && data_pins_out_en === 1'b0) strobe_cnt++;
        end
        checks++;
        if (ack_at != N + 1) begin
            errors++;
            $display("FAIL read_ack_latency: got %0d expected %0d", ack_at, N + 1);
        end
        checks++;
        if (strobe_cnt != N) begin
            errors++;
            $display("FAIL read_strobe_cycles: got %0d expected %0d", strobe_cnt, N);
        end
        checks++;
        if ({a_rdata, address_pins} !== {16'hAA55, 18'h3F000}) begin
            errors++;
            $display("FAIL read_data_addr: got %h expected %h", {a_rdata, address_pins}, {16'hAA55, 18'h3F000});
        end
        checks++;
        if ({CS, OE, WE, data_pins_out_en, b_ack} !== 5'b11100) begin
            errors++;
            $display("FAIL read_recover_pins: got %b expected 11100", {CS, OE, WE, data_pins_out_en, b_ack});
        end
        a_req = 1'b0;
        data_pins_in = 16'h0000;
        @(negedge clk);
        checks++;
        if ({a_ack, busy, a_rdata} !== {2'b00, 16'hAA55}) begin
            errors++;
            $display("FAIL read_after_ack: got %h expected %h", {a_ack, busy, a_rdata}, {2'b00, 16'hAA55});
        end
        model_prev_b = 1'b0;
        exp_a_rdata  = 16'hAA55;
    endtask

    task automatic test_single_write();
        int strobe_cnt, ack_at;
        strobe_cnt = 0; ack_at = 0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 18'h00042; b_wdata = 16'h83E0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b_ack === 1'b1) begin
                ack_at = k;
                break;
            end
            if (CS === 1'b0 && WE === 1'b0 && OE === 1'b1 && data_pins_out_en === 1'b1 && grant_b === 1'b1) strobe_cnt++;
        end
        checks++;
        if (ack_at != N + 1 || strobe_cnt != N) begin
            errors++;
            $display("FAIL write_timing: got ack %0d strobes %0d expected ack %0d strobes %0d", ack_at, strobe_cnt, N + 1, N);
        end
        checks++;
        if ({WE, CS, OE, data_pins_out_en, data_pins_out, address_pins} !== {4'b1111, 16'h83E0, 18'h00042}) begin
            errors++;
            $display("FAIL write_hold: got %h expected %h", {WE, CS, OE, data_pins_out_en, data_pins_out, address_pins}, {4'b1111, 16'h83E0, 18'h00042});
        end
        checks++;
        if (b_rdata !== exp_b_rdata) begin
            errors++;
            $display("FAIL write_rdata_kept: got %h expected %h", b_rdata, exp_b_rdata);
        end
        b_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_pins_out_en, b_ack, address_pins} !== {2'b00, 18'h00042}) begin
            errors++;
            $display("FAIL write_after_ack: got %h expected %h", {data_pins_out_en, b_ack, address_pins}, {2'b00, 18'h00042});
        end
        model_prev_b = 1'b1;
    endtask

    task automatic test_contention();
        bit ack_port[$];
        int ack_cyc[$];
        bit a_re, b_re, prev, w;
        a_re = 1'b0; b_re = 1'b0;
        data_pins_in = 16'hC3C3;
        a_we = 1'b0; a_addr = 18'h01111;
        b_we = 1'b1; b_addr = 18'h02222; b_wdata = 16'h7777;
        a_req = 1'b1; b_req = 1'b1;
        for (int k = 1; k <= 100 && ack_port.size() < 6; k++) begin
            @(negedge clk);
            if (a_re) begin a_req = 1'b1; a_re = 1'b0; end
            if (b_re) begin b_req = 1'b1; b_re = 1'b0; end
            if (a_ack === 1'b1) begin ack_port.push_back(1'b0); ack_cyc.push_back(k); a_req = 1'b0; a_re = 1'b1; end
            if (b_ack === 1'b1) begin ack_port.push_back(1'b1); ack_cyc.push_back(k); b_req = 1'b0; b_re = 1'b1; end
        end
        a_req = 1'b0; b_req = 1'b0;
        checks++;
        if (ack_port.size() != 6) begin
            errors++;
            $display("FAIL contention_count: got %0d acks expected 6", ack_port.size());
        end
        prev = model_prev_b;
        for (int i = 0; i < ack_port.size(); i++) begin
            w = model_pick(1'b1, 1'b1, prev);
            prev = w;
            checks++;
            if (ack_port[i] !== w) begin
                errors++;
                $display("FAIL contention_order[%0d]: got port %0d expected port %0d", i, ack_port[i], w);
            end
        end
        for (int i = 2; i < ack_cyc.size(); i++) begin
            checks++;
            if (ack_cyc[i] - ack_cyc[i-2] != 2 * (N + 2)) begin
                errors++;
                $display("FAIL contention_spacing[%0d]: got %0d expected %0d", i, ack_cyc[i] - ack_cyc[i-2], 2 * (N + 2));
            end
        end
        model_prev_b = prev;
        exp_a_rdata  = 16'hC3C3;
        for (int k = 0; k < 20 && busy !== 1'b0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_rdata !== exp_a_rdata) begin
            errors++;
            $display("FAIL contention_rdata: got %h expected %h", a_rdata, exp_a_rdata);
        end
    endtask

    task automatic test_a_during_b();
        int a_at, b_at;
        a_at = 0; b_at = 0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 18'h00077; b_wdata = 16'h1111;
        repeat (2) @(negedge clk);
        checks++;
        if ({grant_b, busy} !== 2'b11) begin
            errors++;
            $display("FAIL b_in_flight: got %b expected 11", {grant_b, busy});
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 18'h2AAAA; data_pins_in = 16'h0F0F;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (b_ack === 1'b1) begin b_at = k; b_req = 1'b0; end
            if (a_ack === 1'b1) begin a_at = k; break; end
        end
        a_req = 1'b0;
        checks++;
        if (a_at < 1 || a_at > 2 * (N + 2) || b_at == 0 || b_at >= a_at) begin
            errors++;
            $display("FAIL a_wait_bound: got a_ack at %0d b_ack at %0d expected a within 1..%0d after b", a_at, b_at, 2 * (N + 2));
        end
        checks++;
        if ({a_rdata, address_pins} !== {16'h0F0F, 18'h2AAAA}) begin
            errors++;
            $display("FAIL a_after_b_data: got %h expected %h", {a_rdata, address_pins}, {16'h0F0F, 18'h2AAAA});
        end
        model_prev_b = 1'b0;
        exp_a_rdata  = 16'h0F0F;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            bit [1:0]    mask;
            bit          exp_port[$];
            bit          p, w, wr;
            int          exp_cyc;
            logic [15:0] pin_val;
            mask = 2'($urandom_range(1, 3));
            a_we = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
            a_addr = 18'($urandom); b_addr = 18'($urandom);
            a_wdata = 16'($urandom); b_wdata = 16'($urandom);
            pin_val = 16'($urandom);
            data_pins_in = pin_val;
            w = model_pick(mask[0], mask[1], model_prev_b);
            exp_port.push_back(w);
            if (mask == 2'b11) exp_port.push_back(!w);
            model_prev_b = exp_port[exp_port.size() - 1];
            exp_cyc = N + 1;
            a_req = mask[0]; b_req = mask[1];
            for (int k = 1; k <= 40 && exp_port.size() > 0; k++) begin
                @(negedge clk);
                if (a_ack === 1'b1 && b_ack === 1'b1) begin
                    checks++; errors++;
                    $display("FAIL rand_both_ack: iter %0d cycle %0d", it, k);
                end else if (a_ack === 1'b1 || b_ack === 1'b1) begin
                    p  = b_ack;
                    wr = p ? b_we : a_we;
                    checks++;
                    if (p !== exp_port[0] || k != exp_cyc) begin
                        errors++;
                        $display("FAIL rand_grant: iter %0d got port %0d at %0d expected port %0d at %0d", it, p, k, exp_port[0], exp_cyc);
                    end
                    checks++;
                    if (address_pins !== (p ? b_addr : a_addr) || data_pins_out_en !== wr) begin
                        errors++;
                        $display("FAIL rand_addr: iter %0d got %h/%b expected %h/%b", it, address_pins, data_pins_out_en, p ? b_addr : a_addr, wr);
                    end
                    if (wr) begin
                        checks++;
                        if (data_pins_out !== (p ? b_wdata : a_wdata)) begin
                            errors++;
                            $display("FAIL rand_wdata: iter %0d got %h expected %h", it, data_pins_out, p ? b_wdata : a_wdata);
                        end
                    end else if (p) begin
                        exp_b_rdata = pin_val;
                    end else begin
                        exp_a_rdata = pin_val;
                    end
                    checks++;
                    if ({a_rdata, b_rdata} !== {exp_a_rdata, exp_b_rdata}) begin
                        errors++;
                        $display("FAIL rand_rdata: iter %0d got %h expected %h", it, {a_rdata, b_rdata}, {exp_a_rdata, exp_b_rdata});
                    end
                    if (p) b_req = 1'b0; else a_req = 1'b0;
                    void'(exp_port.pop_front());
                    exp_cyc += N + 2;
                    pin_val = 16'($urandom);
                    data_pins_in = pin_val;
                end
            end
            a_req = 1'b0; b_req = 1'b0;
            checks++;
            if (exp_port.size() != 0) begin
                errors++;
                $display("FAIL rand_timeout: iter %0d got %0d acks missing expected 0", it, exp_port.size());
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle: iter %0d got busy %b expected 0", it, busy);
            end
        end
    endtask

`ifdef SRAM_ARBITER_BYTE_LANES_EN
    task automatic test_byte_lanes();
        logic [2:0] ops_we = 3'b011;
        logic [5:0] ops_be = {2'b11, 2'b00, 2'b10};
        for (int i = 0; i < 3; i++) begin
            logic [1:0] be, exp_lanes;
            int bad, ack_at;
            bad = 0; ack_at = 0;
            be = ops_be[2*i +: 2];
            exp_lanes = ops_we[i] ? ~be : 2'b00;
            a_req = 1'b1; a_we = ops_we[i]; a_be = be; a_addr = 18'(i + 5); data_pins_in = 16'hBEEF;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (a_ack === 1'b1) begin ack_at = k; break; end
                if (CS === 1'b0 && {UB, LB} !== exp_lanes) bad++;
            end
            checks++;
            if (bad != 0 || ack_at != N + 1 || {UB, LB} !== 2'b11) begin
                errors++;
                $display("FAIL byte_lanes[%0d]: got bad %0d ack %0d lanes %b expected 0 %0d 11", i, bad, ack_at, {UB, LB}, N + 1);
            end
            a_req = 1'b0;
            @(negedge clk);
        end
        model_prev_b = 1'b0;
        exp_a_rdata  = 16'hBEEF;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_a_during_b();
        test_random();
`ifdef SRAM_ARBITER_BYTE_LANES_EN
        test_byte_lanes();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
